dmem_sync: RTL

Parametrised, synchronous data memory for the core's load/store stage. It replaces the combinational data memory with a registered-read RAM and adds the following:
- byte, halfword and word accesses, with sign or zero extension on loads
- a valid/ready request handshake
- misalignment error reporting
- a hardware clear sweep after reset

It sits between the MEM stage and the RAM array. Responses arrive one cycle after acceptance.

---
 rtl/dmem_sync_pkg.sv | 12 +
 rtl/dmem_sync_if.sv | 23 ++
 rtl/dmem_lane_align.sv | 39 +++
 rtl/dmem_sync.sv | 72 +++++++
 4 files changed

// File: rtl/dmem_sync_pkg.sv
// dmem_sync_pkg: shared constants and types for the synchronous data memory.
//   DMEM_ADDR_BITS   default word-index width
//   SZ_*             req_size encodings (SZ_ILL is the illegal encoding)
//   state_t          sweep/serve FSM states
package dmem_sync_pkg;
  localparam int DMEM_ADDR_BITS = 10;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
endpackage

// File: rtl/dmem_sync_if.sv
// dmem_sync_if: load/store request and response bundle between the MEM stage and dmem_sync.
//   master: MEM stage (drives req_*, except req_ready; receives rsp_*)
//   slave : dmem_sync (drives req_ready and rsp_*)
interface dmem_sync_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane placement for stores and extraction/extension for loads.
//   size/offset/is_unsigned  access description (offset = addr[1:0])
//   wdata -> wmask/wdata_pos store lanes and data positioned in the word
//   rword -> ldata           extracted, extended load data (0 on error)
//   err                      misaligned or illegal size
module dmem_lane_align import dmem_sync_pkg::*; #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_pos,
  output logic [31:0] ldata,
  output logic        err
);
  logic [2:0]  nbytes;
  logic [1:0]  lane;
  logic [3:0]  base_mask;
  logic [31:0] size_mask;
  logic [31:0] raw;
  // lane is the least-significant physical byte lane of the access; in
  // big-endian mode the access occupies the top of the word at offset 0
  always_comb begin
    err = size == SZ_ILL || (size == SZ_HALF && offset[0]) || (size == SZ_WORD && offset != 2'd0);
    nbytes = size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
    base_mask = size == SZ_BYTE ? 4'b0001 : size == SZ_HALF ? 4'b0011 : 4'b1111;
    size_mask = size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff;
    lane = err ? 2'd0 : BIG_ENDIAN ? 2'(3'd4 - {1'b0, offset} - nbytes) : offset;
    wmask = err ? 4'b0000 : 4'(base_mask << lane);
    wdata_pos = (wdata & size_mask) << {lane, 3'b000};
    raw = (rword >> {lane, 3'b000}) & size_mask;
    ldata = err ? '0 :
            size == SZ_BYTE ? {{24{~is_unsigned & raw[7]}}, raw[7:0]} :
            size == SZ_HALF ? {{16{~is_unsigned & raw[15]}}, raw[15:0]} : raw;
  end
endmodule

// File: rtl/dmem_sync.sv
// dmem_sync: registered-response data memory with sub-word access, error reporting and post-reset clear.
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    request/response bundle (slave side)
module dmem_sync import dmem_sync_pkg::*; #(
  parameter int ADDR_BITS      = DMEM_ADDR_BITS,
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic        clk,
  input logic        reset,
  dmem_sync_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  logic [31:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d, idx;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic accept, err;
  logic [3:0] wmask;
  logic [31:0] wdata_pos, ldata;
  logic unused_addr;
  assign idx = bus.req_addr[ADDR_BITS+1:2];
  assign unused_addr = ^bus.req_addr[31:ADDR_BITS+2];
  assign bus.req_ready = reset && state_q == ST_IDLE;
  assign accept = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err = rsp_err_q;
  dmem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size(bus.req_size),
    .offset(bus.req_addr[1:0]),
    .is_unsigned(bus.req_unsigned),
    .wdata(bus.req_wdata),
    .rword(mem[idx]),
    .wmask,
    .wdata_pos,
    .ldata,
    .err
  );
  always_comb begin
    state_d = state_q == ST_CLEAR && &cnt_q ? ST_IDLE : state_q;
    cnt_d = state_q == ST_CLEAR ? cnt_q + 1'b1 : cnt_q;
    rsp_valid_d = accept;
    rsp_err_d = accept && err;
    rsp_rdata_d = accept && !bus.req_we ? ldata : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RST_STATE;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  // wmask is already zero for faulting accesses, so errors never write
  always_ff @(posedge clk) begin
    if (reset && state_q == ST_CLEAR) mem[cnt_q] <= '0;
    else if (accept && bus.req_we)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata_pos[8*i +: 8];
  end
endmodule
